// File: rtl/debug_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : debug_ctrl
// Description : Debugger command sequencer. It sits between the UART receiver,
//               the UART transmitter and the MIPS pipeline. It decodes
//               one-byte host commands, gates the pipeline clock enable for
//               run / single-step / clear, and streams a DUMP_BYTES-long
//               debug snapshot to the transmitter one byte at a time using a
//               start/done handshake.
//
// Commands    : 'c' 0x63 run    'p' 0x70 step    'r' 0x72 clear
//               'd' 0x64 dump   'h' 0x68 halt (honoured only while running)
//
// Ports       : clk         system clock, all logic on posedge
//               reset       synchronous, active-high reset
//               rx_data     received command byte
//               rx_done     receiver done (level, one rising edge per byte)
//               halt        pipeline reached a halt instruction (level)
//               tx_done     transmitter finished current byte (level)
//               dump_data   snapshot byte, valid 1 cycle after dump_addr
//               tx_start    one-cycle pulse: transmit tx_data
//               tx_data     byte to transmit, held until tx_done rises
//               dump_addr   snapshot byte index
//               pipe_en     pipeline clock enable
//               pipe_clear  pipeline synchronous clear
//               busy        high in every state except IDLE and RUN
//
// Build macro : STEP_AUTO_DUMP_EN - when defined, every single-step is
//               followed by a full snapshot dump; when undefined the step
//               returns to IDLE and the host must request 'd' itself.
//
// Revision    : 1.0 - initial release
// ============================================================================

module debug_ctrl #(
    parameter int DUMP_BYTES = 16,
    parameter int ADDR_W     = 4,
    parameter int CLR_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              halt,
    input  logic              tx_done,
    input  logic [7:0]        dump_data,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              pipe_en,
    output logic              pipe_clear,
    output logic              busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [7:0] c_CMD_RUN   = 8'h63;  // 'c'
    localparam logic [7:0] c_CMD_STEP  = 8'h70;  // 'p'
    localparam logic [7:0] c_CMD_CLEAR = 8'h72;  // 'r'
    localparam logic [7:0] c_CMD_DUMP  = 8'h64;  // 'd'
    localparam logic [7:0] c_CMD_HALT  = 8'h68;  // 'h'

    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(DUMP_BYTES - 1);

    // The clear counter is preloaded with CLR_CYCLES-1 and counts down to 0,
    // so pipe_clear stays high for exactly CLR_CYCLES cycles.
    localparam int                c_CNT_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CLR_LOAD = c_CNT_W'(CLR_CYCLES - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_STEP  = 3'd2,
        S_CLEAR = 3'd3,
        S_LOAD  = 3'd4,
        S_SEND  = 3'd5,
        S_WAIT  = 3'd6
    } state_t;

    state_t               r_state;
    logic                 r_rx_done_q;
    logic                 r_tx_done_q;
    logic [ADDR_W-1:0]    r_idx;
    logic [c_CNT_W-1:0]   r_clr_cnt;

    // ------------------------------------------------------------------------
    // Edge detection and command decode
    // ------------------------------------------------------------------------
    // rx_done and tx_done are levels that may stay high for many cycles; only
    // their rising edges carry meaning. Because r_tx_done_q is refreshed every
    // cycle, a tx_done that is already high when WAIT is entered produces no
    // acknowledge until it has dropped and risen again.
    logic w_cmd_stb;
    logic w_tx_ack;
    logic w_cmd_run;
    logic w_cmd_step;
    logic w_cmd_clear;
    logic w_cmd_dump;
    logic w_cmd_halt;

    assign w_cmd_stb   = rx_done & ~r_rx_done_q;
    assign w_tx_ack    = tx_done & ~r_tx_done_q;

    assign w_cmd_run   = w_cmd_stb && (rx_data == c_CMD_RUN);
    assign w_cmd_step  = w_cmd_stb && (rx_data == c_CMD_STEP);
    assign w_cmd_clear = w_cmd_stb && (rx_data == c_CMD_CLEAR);
    assign w_cmd_dump  = w_cmd_stb && (rx_data == c_CMD_DUMP);
    assign w_cmd_halt  = w_cmd_stb && (rx_data == c_CMD_HALT);

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    // All outputs are registered: each is updated on the same edge as the
    // state transition that implies it, so the value seen while sitting in a
    // state is the one that state calls for (pipe_en is high for every cycle
    // spent in RUN / STEP, busy mirrors "not IDLE and not RUN", and so on).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rx_done_q <= 1'b0;
            r_tx_done_q <= 1'b0;
            r_idx       <= '0;
            r_clr_cnt   <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            dump_addr   <= '0;
            pipe_en     <= 1'b0;
            pipe_clear  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            r_rx_done_q <= rx_done;
            r_tx_done_q <= tx_done;

            // tx_start is a single-cycle pulse, raised only from SEND.
            tx_start    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    pipe_en    <= 1'b0;
                    pipe_clear <= 1'b0;
                    busy       <= 1'b0;
                    if (w_cmd_run) begin
                        r_state <= S_RUN;
                        pipe_en <= 1'b1;
                    end else if (w_cmd_step) begin
                        r_state <= S_STEP;
                        pipe_en <= 1'b1;
                        busy    <= 1'b1;
                    end else if (w_cmd_clear) begin
                        r_state    <= S_CLEAR;
                        pipe_clear <= 1'b1;
                        busy       <= 1'b1;
                        r_clr_cnt  <= c_CLR_LOAD;
                    end else if (w_cmd_dump) begin
                        r_state   <= S_LOAD;
                        r_idx     <= '0;
                        dump_addr <= '0;
                        busy      <= 1'b1;
                    end
                end

                // Only a halt (pin or 'h') leaves RUN; a simultaneous pin and
                // command are one event and start a single dump.
                S_RUN: begin
                    if (w_cmd_halt || halt) begin
                        r_state   <= S_LOAD;
                        pipe_en   <= 1'b0;
                        r_idx     <= '0;
                        dump_addr <= '0;
                        busy      <= 1'b1;
                    end
                end

                // Exactly one enabled pipeline cycle has elapsed on arrival.
                S_STEP: begin
                    pipe_en <= 1'b0;
`ifdef STEP_AUTO_DUMP_EN
                    r_state   <= S_LOAD;
                    r_idx     <= '0;
                    dump_addr <= '0;
                    busy      <= 1'b1;
`else
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
`endif
                end

                S_CLEAR: begin
                    if (r_clr_cnt == '0) begin
                        r_state    <= S_IDLE;
                        pipe_clear <= 1'b0;
                        busy       <= 1'b0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt - 1'b1;
                    end
                end

                // dump_addr was presented on entry; one cycle covers the
                // snapshot source's read latency.
                S_LOAD: begin
                    r_state <= S_SEND;
                end

                S_SEND: begin
                    tx_data  <= dump_data;
                    tx_start <= 1'b1;
                    r_state  <= S_WAIT;
                end

                // tx_data holds its value here until the transmitter acks.
                S_WAIT: begin
                    if (w_tx_ack) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            r_idx     <= r_idx + 1'b1;
                            dump_addr <= r_idx + 1'b1;
                            r_state   <= S_LOAD;
                        end
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    pipe_en    <= 1'b0;
                    pipe_clear <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_debug_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_ctrl
// Description : Self-checking bench for debug_ctrl. Snapshot contents and
//               transmitter delays are randomised; expected bytes, pulse
//               counts and enable durations are computed from the command
//               rules and compared with immediate assertions.
//               Honours STEP_AUTO_DUMP_EN the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_debug_ctrl;

    localparam int DUMP_BYTES = 16;
    localparam int ADDR_W     = 4;
    localparam int CLR_CYCLES = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_done;
    logic              halt;
    logic              tx_done;
    logic [7:0]        dump_data;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic [ADDR_W-1:0] dump_addr;
    logic              pipe_en;
    logic              pipe_clear;
    logic              busy;

    debug_ctrl #(
        .DUMP_BYTES (DUMP_BYTES),
        .ADDR_W     (ADDR_W),
        .CLR_CYCLES (CLR_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .halt       (halt),
        .tx_done    (tx_done),
        .dump_data  (dump_data),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .dump_addr  (dump_addr),
        .pipe_en    (pipe_en),
        .pipe_clear (pipe_clear),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Snapshot source: synchronous read, data valid one cycle after address.
    logic [7:0] mem [DUMP_BYTES];
    always @(posedge clk) dump_data <= mem[dump_addr];

    // Pulse / level counters sampled mid-cycle.
    int n_tx_start   = 0;
    int n_pipe_en    = 0;
    int n_pipe_clear = 0;
    always @(negedge clk) begin
        if (tx_start   === 1'b1) n_tx_start   <= n_tx_start + 1;
        if (pipe_en    === 1'b1) n_pipe_en    <= n_pipe_en + 1;
        if (pipe_clear === 1'b1) n_pipe_clear <= n_pipe_clear + 1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_mem(input bit ramp);
        for (int i = 0; i < DUMP_BYTES; i++)
            mem[i] = ramp ? 8'(8'hA0 + i) : 8'($urandom);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic wait_start(output bit found);
        found = 1'b0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (tx_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_start"},   tx_start,   0);
        check({tag, "_tx_data"},    tx_data,    0);
        check({tag, "_dump_addr"},  dump_addr,  0);
        check({tag, "_pipe_en"},    pipe_en,    0);
        check({tag, "_pipe_clear"}, pipe_clear, 0);
        check({tag, "_busy"},       busy,       0);
    endtask

    // Act as the transmitter for snapshot bytes first..last: each byte must
    // arrive in index order carrying mem[index], stay stable while waiting,
    // and advance only on a fresh tx_done rising edge.
    task automatic do_dump(input int first, input int last, input int lo, input int hi);
        int base;
        int d;
        bit found;
        bit stable;
        base = n_tx_start;
        for (int i = first; i <= last; i++) begin
            wait_start(found);
            check("tx_start_seen", found, 1);
            if (!found) return;
            check("tx_data", tx_data, mem[i]);
            check("dump_addr", dump_addr, i);
            d = int'($urandom_range(hi, lo));
            stable = 1'b1;
            repeat (d) begin
                tick();
                if (tx_data !== mem[i] || tx_start !== 1'b0 || busy !== 1'b1 ||
                    dump_addr !== ADDR_W'(i))
                    stable = 1'b0;
            end
            check("wait_hold", stable, 1);
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        check("tx_start_count", n_tx_start - base, last - first + 1);
        if (last == DUMP_BYTES - 1)
            check("dump_end_busy", busy, 0);
    endtask

    // Run for len cycles, stop via pin and/or 'h', then expect exactly one dump.
    task automatic run_halt(input int len, input bit by_pin, input bit by_cmd,
                            input int lo, input int hi);
        int e0;
        int s0;
        e0 = n_pipe_en;
        fill_mem(1'b0);
        send_cmd(8'h63);
        check("run_en", pipe_en, 1);
        check("run_busy", busy, 0);
        for (int c = 1; c < len; c++) begin
            if (c == len / 2) begin
                rx_data = 8'h63;
                rx_done = 1'b1;
            end
            if (c == len / 2 + 2) rx_done = 1'b0;
            tick();
        end
        if (by_pin) halt = 1'b1;
        if (by_cmd) begin
            rx_data = 8'h68;
            rx_done = 1'b1;
        end
        tick();
        halt    = 1'b0;
        rx_done = 1'b0;
        check("run_stop_en", pipe_en, 0);
        check("run_len", n_pipe_en - e0, len);
        do_dump(0, DUMP_BYTES - 1, lo, hi);
        s0 = n_tx_start;
        repeat (30) tick();
        check("no_extra_dump", n_tx_start - s0, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  e0;
        int  c0;
        int  s0;
        bit  found;

        // ---- reset ----
        reset   = 1'b1;
        rx_data = 8'h00;
        rx_done = 1'b0;
        halt    = 1'b0;
        tx_done = 1'b0;
        fill_mem(1'b1);
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // ---- 'd' with ramp contents and 20-cycle transmitter ----
        send_cmd(8'h64);
        check("dump_busy", busy, 1);
        do_dump(0, DUMP_BYTES - 1, 20, 20);
        tick();
        check("after_dump_en", pipe_en, 0);

        // ---- run / halt variants ----
        run_halt(50, 1'b1, 1'b0, 20, 20);
        run_halt(int'($urandom_range(40, 8)), 1'b0, 1'b1, 6, 1);
        run_halt(int'($urandom_range(40, 8)), 1'b1, 1'b1, 6, 1);
        run_halt(int'($urandom_range(40, 8)), 1'($urandom), 1'b1, 4, 1);

        // ---- single step ----
        e0 = n_pipe_en;
        s0 = n_tx_start;
        fill_mem(1'b0);
        send_cmd(8'h70);
        check("step_en", pipe_en, 1);
        check("step_busy", busy, 1);
`ifdef STEP_AUTO_DUMP_EN
        do_dump(0, DUMP_BYTES - 1, 5, 1);
`else
        repeat (10) tick();
        check("step_no_tx", n_tx_start - s0, 0);
`endif
        check("step_len", n_pipe_en - e0, 1);
        check("step_end_busy", busy, 0);

        // ---- clear, with a 'c' and halt arriving mid-clear ----
        e0 = n_pipe_en;
        c0 = n_pipe_clear;
        send_cmd(8'h72);
        check("clear_on", pipe_clear, 1);
        check("clear_en_off", pipe_en, 0);
        rx_data = 8'h63;
        rx_done = 1'b1;
        halt    = 1'b1;
        tick();
        rx_done = 1'b0;
        repeat (8) tick();
        halt = 1'b0;
        check("clear_len", n_pipe_clear - c0, CLR_CYCLES);
        check("clear_en_cnt", n_pipe_en - e0, 0);
        check("clear_then_idle_en", pipe_en, 0);
        check("clear_then_idle_busy", busy, 0);

        // ---- rx_done held high: one RUN entry; tx_done stuck high into WAIT ----
        fill_mem(1'b0);
        e0 = n_pipe_en;
        rx_data = 8'h63;
        rx_done = 1'b1;
        repeat (30) tick();
        rx_done = 1'b0;
        repeat (4) tick();
        halt    = 1'b1;
        tx_done = 1'b1;
        tick();
        halt = 1'b0;
        check("held_run_len", n_pipe_en - e0, 34);
        s0 = n_tx_start;
        wait_start(found);
        check("stuck_first_start", found, 1);
        check("stuck_first_data", tx_data, mem[0]);
        repeat (10) tick();
        check("stuck_no_advance", n_tx_start - s0, 1);
        check("stuck_addr", dump_addr, 0);
        check("stuck_busy", busy, 1);
        tx_done = 1'b0;
        repeat (2) tick();
        check("stuck_low_no_advance", n_tx_start - s0, 1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        do_dump(1, DUMP_BYTES - 1, 4, 1);

        // ---- reset during byte-5 WAIT, then a fresh dump ----
        fill_mem(1'b0);
        send_cmd(8'h64);
        do_dump(0, 4, 3, 1);
        wait_start(found);
        check("b5_start", found, 1);
        check("b5_data", tx_data, mem[5]);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check_all_zero("mid_dump_reset");
        reset = 1'b0;
        tick();
        fill_mem(1'b0);
        send_cmd(8'h64);
        do_dump(0, DUMP_BYTES - 1, 3, 1);

        // ---- reset during clear ----
        send_cmd(8'h72);
        tick();
        reset = 1'b1;
        tick();
        check_all_zero("mid_clear_reset");
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/debug_ctrl.md
Name: debug_ctrl

Overview:
Command sequencer for the DEBUGGER path, sitting between the UART receiver, the UART transmitter and the MIPS pipeline.
- Decodes one-byte commands from the UART receiver.
- Gates the pipeline clock enable for run, single-step and clear.
- Serialises a DUMP_BYTES-long debug snapshot to the UART transmitter with a byte-level handshake.

Parameters:
DUMP_BYTES, 16, bytes sent per dump (index 0..DUMP_BYTES-1)
ADDR_W, 4, width of dump_addr; 2**ADDR_W >= DUMP_BYTES
CLR_CYCLES, 4, cycles pipe_clear is held high on a clear command

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
rx_data  in  8  byte from UART receiver
rx_done  in  1  receiver done; level, held high for several cycles per byte
halt  in  1  pipeline reached a halt instruction (level)
tx_done  in  1  transmitter finished current byte (level, may stay high)
dump_data  in  8  snapshot byte at dump_addr; synchronous source, valid 1 cycle after dump_addr changes
tx_start  out  1  one-cycle pulse: transmit tx_data
tx_data  out  8  byte to transmit; stable from tx_start until tx_done rises
dump_addr  out  ADDR_W  snapshot byte index
pipe_en  out  1  pipeline clock enable
pipe_clear  out  1  pipeline synchronous clear
busy  out  1  high in every state except IDLE and RUN

Behaviour:
- Reset (any cycle, including mid-dump or mid-clear): state=IDLE; all outputs 0; edge registers cleared.
- cmd_stb = rx_done & ~rx_done_q; tx_ack = tx_done & ~tx_done_q. Both edge registers are updated every cycle.
- Commands (on cmd_stb): 'c' 0x63 run; 'p' 0x70 step; 'r' 0x72 clear; 'd' 0x64 dump; 'h' 0x68 halt. Other values are ignored.
- A cmd_stb in any state not listed below is dropped. There is no command queue.
- IDLE: pipe_en=0.
  - 'c' -> RUN.
  - 'p' -> STEP.
  - 'r' -> CLEAR.
  - 'd' -> LOAD with idx=0.
- RUN: pipe_en=1.
  - 'h' cmd_stb or halt=1 -> LOAD with idx=0; pipe_en=0 from the next cycle.
  - If both happen in the same cycle, a single dump runs.
  - 'c', 'p', 'r', 'd' are ignored in RUN.
- STEP: pipe_en=1 for exactly one cycle, then -> IDLE (or LOAD, see optional feature).
- CLEAR: pipe_clear=1 for CLR_CYCLES consecutive cycles with pipe_en=0, then -> IDLE.
- LOAD: dump_addr=idx; wait 1 cycle for read latency -> SEND.
- SEND: tx_data<=dump_data; tx_start=1 for one cycle -> WAIT.
- WAIT: hold tx_data; on tx_ack:
  - if idx==DUMP_BYTES-1 -> IDLE;
  - else idx+1 -> LOAD.
- A tx_done already high on entry to WAIT does not count. Only a rising edge after tx_start counts.
- Dump latency per byte is 2 cycles plus the transmitter time. idx does not wrap; it stops at DUMP_BYTES-1.
- Halt during STEP or CLEAR is ignored. Halt is only sampled in RUN.

Optional Feature:
STEP_AUTO_DUMP_EN
- Defined: STEP goes to LOAD (idx=0) after its single pipe_en cycle, so every step sends a full snapshot.
- Undefined: STEP returns to IDLE, and the host must send 'd' explicitly.

Test Plan:
- Reset, then 'd' with dump_data=idx+0xA0 and tx_done pulsed 20 cycles after each tx_start -> 16 tx_start pulses; tx_data 0xA0..0xAF in order; busy high throughout; IDLE after the 16th tx_ack.
- 'c', then halt=1 after 50 cycles -> pipe_en high exactly 50 cycles, then drops; one full dump follows. A 'c' sent during RUN has no effect.
- 'p' (macro undefined) -> pipe_en high exactly 1 cycle; no tx_start. Repeat with macro defined -> 1 cycle of pipe_en, then 16-byte dump.
- 'r' -> pipe_clear high exactly 4 cycles, pipe_en 0; a 'c' arriving in cycle 2 is dropped (state IDLE afterwards).
- rx_done held high for 30 cycles with rx_data=0x63 -> a single RUN entry; tx_done stuck high entering WAIT -> no advance until it falls and rises again.
- Assert reset during the byte-5 WAIT -> all outputs 0 next cycle; a subsequent 'd' restarts from dump_addr=0.
